// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared types and helpers for the one-to-N stream demultiplexer.
// Rev     : 1.0  initial release
// ============================================================================
package demux_pkg;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select width with a floor of one bit so a single-output build still has a port.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module  : demux_out_slot
// Brief   : One-entry output register with load/drain handshake control.
// Rev     : 1.0  initial release
// ============================================================================
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                drain_i,
  input  logic [NUM_BITS-1:0] data_i,
  output logic                valid_o,
  output logic [NUM_BITS-1:0] data_o
);

  slot_state_e         state_q, state_d;
  logic [NUM_BITS-1:0] data_q,  data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load into a full slot only happens alongside a drain, so it stays full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      data_d = data_i;
    end
    case (state_q)
      SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain_i && !load_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/demux_n_bit_length_reg.sv
`default_nettype none
// ============================================================================
// Module  : demux_n_bit_length_reg
// Brief   : Registered one-to-N stream demux with a one-word slot per channel.
// Rev     : 1.0  initial release
// ============================================================================
module demux_n_bit_length_reg
  import demux_pkg::*;
#(
  parameter  int NUM_OUTPUTS = 8,
  parameter  int NUM_BITS    = 32,
  localparam int SEL_W       = sel_width(NUM_OUTPUTS),
  localparam int OCC_W       = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_BITS-1:0]    in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [NUM_OUTPUTS-1:0] out_valid,
  input  logic [NUM_OUTPUTS-1:0] out_ready,
  output logic [NUM_BITS-1:0]    out_data [NUM_OUTPUTS],
  output logic [OCC_W-1:0]       occupancy
);

  logic [SEL_W-1:0]       w_sel;
  logic                   w_accept;
  logic [NUM_OUTPUTS-1:0] w_load;
  logic [NUM_OUTPUTS-1:0] w_drain;
  logic [OCC_W-1:0]       w_n_drain;
  logic [OCC_W-1:0]       occ_q, occ_d;

  // With a single channel the select input carries no information.
  generate
    if (NUM_OUTPUTS == 1) begin : g_sel_single
      assign w_sel = '0;
    end else begin : g_sel_multi
      assign w_sel = in_sel;
    end
  endgenerate

  assign in_ready = !out_valid[w_sel] | out_ready[w_sel];
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
      assign w_load[k]  = w_accept & (w_sel == SEL_W'(k));
      assign w_drain[k] = out_valid[k] & out_ready[k];

      demux_out_slot #(
        .NUM_BITS (NUM_BITS)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load[k]),
        .drain_i (w_drain[k]),
        .data_i  (in_data),
        .valid_o (out_valid[k]),
        .data_o  (out_data[k])
      );
    end
  endgenerate

  // At most one load per cycle, so the net change is one accept minus all drains.
  always_comb begin
    w_n_drain = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      w_n_drain = w_n_drain + OCC_W'(w_drain[k]);
    end
    occ_d = occ_q + OCC_W'(w_accept) - w_n_drain;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule : demux_n_bit_length_reg
`default_nettype wire

// File: tb/tb_demux_n_bit_length_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_n_bit_length_reg
// Brief   : Scoreboard bench for the one-to-N stream demux (8 x 32-bit).
// Rev     : 1.0  initial release
// ============================================================================
module tb_demux_n_bit_length_reg;

  localparam int N = 8;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [W-1:0]  out_data [N];
  logic [3:0]    occupancy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  demux_n_bit_length_reg #(
    .NUM_OUTPUTS (N),
    .NUM_BITS    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; the handshake resolves at the next rising edge.
  task automatic drive(input logic v, input int sel, input logic [W-1:0] d,
                       input logic [N-1:0] rdy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_sel    = 3'(sel);
    in_data   = d;
    out_ready = rdy;
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back('{sel, d});
  endtask

  // Monitor: every channel handing off a word must match the oldest expected word for it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (idx < 0 && sb[i].ch == k) idx = i;
            end
            if (idx < 0) begin
              chk($sformatf("unexpected_word_ch%0d", k), 64'(out_data[k]), 64'hDEAD_0000);
            end else begin
              chk($sformatf("data_ch%0d", k), 64'(out_data[k]), 64'(sb[idx].data));
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    drive(0, 0, 0, 8'h00, acc);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_occupancy", 64'(occupancy), 64'h0);
    chk("reset_in_ready",  64'(in_ready),  64'h1);
    for (int k = 0; k < N; k++) chk($sformatf("reset_out_data%0d", k), 64'(out_data[k]), 64'h0);

    // Sequential fill of all channels
    for (int k = 0; k < N; k++) begin
      drive(1, k, 32'hA0 + 32'(k), 8'h00, acc);
      chk($sformatf("fill_accept%0d", k), 64'(acc), 64'h1);
    end
    drive(1, 3, 32'hB3, 8'h00, acc);
    chk("full_out_valid", 64'(out_valid), 64'hFF);
    chk("full_occupancy", 64'(occupancy), 64'h8);
    chk("full_in_ready",  64'(in_ready),  64'h0);
    for (int k = 0; k < N; k++) chk($sformatf("full_data%0d", k), 64'(out_data[k]), 64'hA0 + 64'(k));
    drive(1, 3, 32'hB3, 8'h00, acc);
    chk("ninth_held", 64'(acc), 64'h0);
    drive(1, 3, 32'hB3, 8'h08, acc);
    chk("ninth_accept_on_drain", 64'(acc), 64'h1);
    drive(0, 0, 0, 8'hFF, acc);
    chk("refill_occupancy", 64'(occupancy), 64'h8);
    chk("refill_data3", 64'(out_data[3]), 64'hB3);
    drive(0, 0, 0, 8'h00, acc);
    chk("drained_occupancy", 64'(occupancy), 64'h0);
    chk("drained_out_valid", 64'(out_valid), 64'h0);

    // Same-channel streaming at full rate
    for (int i = 0; i < 100; i++) begin
      drive(1, 2, 32'h1000 + 32'(i), 8'h04, acc);
      chk("stream_accept", 64'(acc), 64'h1);
      chk("stream_occupancy", 64'(occupancy), (i == 0) ? 64'h0 : 64'h1);
      chk("stream_out_valid", 64'(out_valid), (i == 0) ? 64'h0 : 64'h04);
    end
    drive(0, 0, 0, 8'h04, acc);
    drive(0, 0, 0, 8'h00, acc);
    chk("stream_end_occupancy", 64'(occupancy), 64'h0);

    // Blocked channel 5 must not stall other channels
    drive(1, 5, 32'h55, 8'h00, acc);
    chk("iso_load5", 64'(acc), 64'h1);
    for (int i = 0; i < 6; i++) begin
      drive(1, (i % 2 == 0) ? 1 : 6, 32'h6100 + 32'(i), 8'hDF, acc);
      chk("iso_other_accept", 64'(acc), 64'h1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 32'h5A, 8'hDF, acc);
      chk("iso_stall5", 64'(acc), 64'h0);
    end
    drive(1, 5, 32'h5A, 8'hFF, acc);
    chk("iso_release5", 64'(acc), 64'h1);
    drive(0, 0, 0, 8'hFF, acc);
    chk("iso_data5", 64'(out_data[5]), 64'h5A);
    drive(0, 0, 0, 8'h00, acc);
    chk("iso_end_occupancy", 64'(occupancy), 64'h0);

    // Simultaneous load and multi-channel drain
    drive(1, 0, 32'hC0, 8'h00, acc);
    drive(1, 3, 32'hC3, 8'h00, acc);
    drive(1, 7, 32'hC7, 8'h00, acc);
    drive(1, 0, 32'hD0, 8'h89, acc);
    chk("sim_pre_occupancy", 64'(occupancy), 64'h3);
    chk("sim_accept", 64'(acc), 64'h1);
    drive(0, 0, 0, 8'h00, acc);
    chk("sim_occupancy", 64'(occupancy), 64'h1);
    chk("sim_out_valid", 64'(out_valid), 64'h01);
    chk("sim_data0", 64'(out_data[0]), 64'hD0);
    drive(0, 0, 0, 8'h01, acc);

    // Asynchronous reset with words held
    drive(1, 1, 32'hE1, 8'h00, acc);
    drive(1, 2, 32'hE2, 8'h00, acc);
    drive(1, 4, 32'hE4, 8'h00, acc);
    drive(1, 6, 32'hE6, 8'h00, acc);
    drive(0, 0, 0, 8'h00, acc);
    chk("prerst_occupancy", 64'(occupancy), 64'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'h0);
    chk("async_rst_occupancy", 64'(occupancy), 64'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 8'hFF, acc);
      chk("postrst_out_valid", 64'(out_valid), 64'h0);
      chk("postrst_out_data6", 64'(out_data[6]), 64'h0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_demux_n_bit_length_reg
`default_nettype wire
